ddr_arbiter: RTL and testbench
==============================

DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, read watchdog limit in clock cycles (used only when DDR_ARB_TIMEOUT_EN is defined).
REQ-002 Parameter: WR_FIRST, default 1, 1 = writer wins the first contested grant after reset, 0 = reader wins.
REQ-003 clk0_tb  in  1  sole clock; all logic rising-edge.
REQ-004 rst0_tb  in  1  asynchronous, active-high reset.
REQ-005 phy_init_done  in  1  DDR2 PHY calibrated; no grant while low.
REQ-006 app_af_afull / app_wdf_afull  in  1 each  MIG address FIFO / write-data FIFO almost full.
REQ-007 cmd  out  3  MIG command: 3'b000 write, 3'b001 read.
REQ-008 address  out  31  MIG address; bits [1:0] always 0.
REQ-009 af_we  out  1  address FIFO write strobe; wdf_we  out  1  data FIFO write strobe; w_data  out  128  write beat.
REQ-010 rd_data_valid  in  1, rd_data_fifo_out  in  128  MIG read beats.
REQ-011 wr_req  in  1, wr_addr  in  31, wr_data  in  256, wr_ack  out  1  writer port.
REQ-012 rd_req  in  1, rd_addr  in  31, rd_ack  out  1, rd_out  out  256, rd_out_valid  out  1  reader port.
REQ-013 rd_timeout  out  1  sticky read watchdog flag; debug  out  8  status.

Function
REQ-014 FSM states: IDLE, WR1, WR2, RD_CMD, RD_WAIT; all outputs registered.
REQ-015 IDLE grants only when phy_init_done=1 and app_af_afull=0; a write grant additionally needs app_wdf_afull=0.
REQ-016 Arbitration: one eligible requester is granted; two eligible requesters are granted round-robin, opposite to last_grant; last_grant resets to the reader when WR_FIRST=1 and to the writer when WR_FIRST=0.
REQ-017 On grant, the arbiter latches the address (bits [1:0] forced 0) and, for a write, wr_data; the requester's inputs are don't-care afterwards.
REQ-018 WR1 (the cycle after grant): af_we=1, cmd=000, address=latched, wdf_we=1, w_data=data[127:0], wr_ack=1 for one cycle.
REQ-019 WR2: wdf_we=1, w_data=data[255:128], af_we=0; next state IDLE.
REQ-020 RD_CMD (the cycle after grant): af_we=1, cmd=001, address=latched, rd_ack=1 for one cycle; next state RD_WAIT.
REQ-021 RD_WAIT: the first rd_data_valid beat goes to rd_out[127:0] and the second to rd_out[255:128]; rd_out_valid pulses one cycle, the cycle after the second beat; the FSM then returns to IDLE.
REQ-022 rd_out holds its value until the next completed read.
REQ-023 At most one read is outstanding; no grant of either type is made while in RD_WAIT.
REQ-024 rd_data_valid outside RD_WAIT is ignored for data and increments a 3-bit saturating stray counter.
REQ-025 Minimum spacing: a write occupies 3 cycles grant-to-grant; a read occupies 2 cycles plus the return latency plus 1.
REQ-026 When no strobe is active: af_we=wdf_we=0, cmd and address hold their last values, w_data holds its last value.
REQ-027 debug = {state[2:0], last_grant, rd_timeout, stray_cnt[2:0]}; state codes IDLE=0, WR1=1, WR2=2, RD_CMD=3, RD_WAIT=4.
REQ-028 If phy_init_done falls mid-operation, the current operation completes; no new grants are made.

Reset
REQ-029 rst0_tb=1 immediately forces: state IDLE, cmd=0, address=0, af_we=0, wdf_we=0, w_data=0, wr_ack=0, rd_ack=0, rd_out=0, rd_out_valid=0, rd_timeout=0, stray_cnt=0, last_grant per REQ-016.
REQ-030 Reset during WR1/WR2/RD_WAIT abandons the operation with no ack or valid pulse; beats arriving after release count as stray.

Configuration
REQ-031 Macro DDR_ARB_TIMEOUT_EN defined: a counter runs in RD_WAIT; reaching TIMEOUT_CYCLES without two beats sets rd_timeout (sticky until reset), returns to IDLE with no rd_out_valid, and discards the partial beat.
REQ-032 Macro DDR_ARB_TIMEOUT_EN not defined: RD_WAIT waits indefinitely, no counter logic exists, rd_timeout is tied 0.

Verification
REQ-033 Write then read, single requester: wr_req, wr_addr=31'h13, wr_data={128'hB,128'hA} -> WR1 af_we=1, cmd=000, address=31'h10, w_data=A, wr_ack=1; WR2 w_data=B.
REQ-034 Read return: rd_addr=31'h40; return beats 128'h1 then 128'h2 -> rd_out={128'h2,128'h1}, rd_out_valid pulses 1 cycle after the second beat.
REQ-035 Contention, both requesters held high, WR_FIRST=1 -> grants are W, R, W, R; no grant occurs while in RD_WAIT.
REQ-036 Flow control: app_wdf_afull=1 with both requesting -> only reads are granted; phy_init_done=0 -> af_we never asserts.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=20): read with one beat only -> rd_timeout=1 after 20 cycles, FSM returns to IDLE, no rd_out_valid; without the macro, the FSM stays in RD_WAIT.
REQ-038 Reset asserted in WR2 -> all outputs are 0 the same cycle, no wr_ack on release, and debug[7:5]=0.

Source files
------------

// File: rtl/ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arbiter
//  Description : Two-port (writer/reader) arbiter in front of a DDR2 MIG
//                user interface.  A write issues one address-FIFO command
//                and two 128-bit data beats.  A read issues one command and
//                collects two returned beats into a 256-bit word.  Only one
//                read may be outstanding.  Contested grants alternate.
//  Revision    : 1.0  initial release
//
//  Optional feature macro:
//    DDR_ARB_TIMEOUT_EN - adds a read watchdog. If two beats have not
//                         arrived within TIMEOUT_CYCLES clocks in RD_WAIT,
//                         the read is abandoned and rd_timeout is set
//                         until reset.
//
//  Ports:
//    clk0_tb, rst0_tb            clock, async active-high reset
//    phy_init_done               PHY calibrated; no grant while low
//    app_af_afull, app_wdf_afull MIG address / write-data FIFO almost full
//    cmd, address, af_we         MIG command, address, address-FIFO strobe
//    wdf_we, w_data              MIG write-data strobe and beat
//    rd_data_valid,
//    rd_data_fifo_out            MIG read return beats
//    wr_req, wr_addr, wr_data,
//    wr_ack                      writer port
//    rd_req, rd_addr, rd_ack,
//    rd_out, rd_out_valid        reader port
//    rd_timeout                  sticky read watchdog flag
//    debug                       {state, last_grant, rd_timeout, stray_cnt}
// ============================================================================
module ddr_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WR_FIRST       = 1
) (
  input  logic         clk0_tb,
  input  logic         rst0_tb,
  input  logic         phy_init_done,
  input  logic         app_af_afull,
  input  logic         app_wdf_afull,
  output logic [2:0]   cmd,
  output logic [30:0]  address,
  output logic         af_we,
  output logic         wdf_we,
  output logic [127:0] w_data,
  input  logic         rd_data_valid,
  input  logic [127:0] rd_data_fifo_out,
  input  logic         wr_req,
  input  logic [30:0]  wr_addr,
  input  logic [255:0] wr_data,
  output logic         wr_ack,
  input  logic         rd_req,
  input  logic [30:0]  rd_addr,
  output logic         rd_ack,
  output logic [255:0] rd_out,
  output logic         rd_out_valid,
  output logic         rd_timeout,
  output logic [7:0]   debug
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR1     = 3'd1,
    S_WR2     = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4
  } state_t;

  // last_grant encoding: 1 = writer, 0 = reader.  With WR_FIRST the reader is
  // recorded as last so that the writer wins the first contested grant.
  localparam logic c_LG_RESET = (WR_FIRST != 0) ? 1'b0 : 1'b1;
  localparam logic [30:0] c_ADDR_MASK = ~31'h3;

  state_t         r_state, w_next_state;
  logic           r_last_grant, w_last_grant;
  logic [127:0]   r_data_hi, w_data_hi;
  logic [127:0]   r_beat_lo, w_beat_lo;
  logic           r_have_lo, w_have_lo;
  logic [2:0]     r_stray;

  logic [2:0]     w_cmd;
  logic [30:0]    w_address;
  logic           w_af_we, w_wdf_we, w_wr_ack, w_rd_ack, w_rd_out_valid;
  logic [127:0]   w_w_data;
  logic [255:0]   w_rd_out;

  logic           w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
  logic           w_second_beat, w_to_expire;

  assign w_wr_elig = phy_init_done & ~app_af_afull & ~app_wdf_afull & wr_req;
  assign w_rd_elig = phy_init_done & ~app_af_afull & rd_req;
  // Writer wins when alone, or when contested and the reader went last.
  assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_last_grant);
  assign w_grant_rd = w_rd_elig & ~w_grant_wr;

  assign w_second_beat = (r_state == S_RD_WAIT) & rd_data_valid & r_have_lo;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_rd_timeout;

  // Counter value k means k full cycles already spent in RD_WAIT.
  assign w_to_expire = (r_state == S_RD_WAIT) && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk0_tb or posedge rst0_tb) begin
    if (rst0_tb) begin
      r_to_cnt     <= '0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_to_cnt     <= (r_state == S_RD_WAIT) ? r_to_cnt + 1'b1 : '0;
      r_rd_timeout <= r_rd_timeout | (w_to_expire & ~w_second_beat);
    end
  end

  assign rd_timeout = r_rd_timeout;
`else
  assign w_to_expire = 1'b0;
  assign rd_timeout  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk0_tb or posedge rst0_tb) begin
    if (rst0_tb) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state and next values of every registered output
  always_comb begin
    w_next_state   = r_state;
    w_last_grant   = r_last_grant;
    w_data_hi      = r_data_hi;
    w_beat_lo      = r_beat_lo;
    w_have_lo      = r_have_lo;
    w_cmd          = cmd;
    w_address      = address;
    w_af_we        = 1'b0;
    w_wdf_we       = 1'b0;
    w_w_data       = w_data;
    w_wr_ack       = 1'b0;
    w_rd_ack       = 1'b0;
    w_rd_out       = rd_out;
    w_rd_out_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_next_state = S_WR1;
          w_last_grant = 1'b1;
          w_cmd        = 3'b000;
          w_address    = wr_addr & c_ADDR_MASK;
          w_af_we      = 1'b1;
          w_wdf_we     = 1'b1;
          w_w_data     = wr_data[127:0];
          w_data_hi    = wr_data[255:128];
          w_wr_ack     = 1'b1;
        end else if (w_grant_rd) begin
          w_next_state = S_RD_CMD;
          w_last_grant = 1'b0;
          w_cmd        = 3'b001;
          w_address    = rd_addr & c_ADDR_MASK;
          w_af_we      = 1'b1;
          w_rd_ack     = 1'b1;
        end
      end

      S_WR1: begin
        w_next_state = S_WR2;
        w_wdf_we     = 1'b1;
        w_w_data     = r_data_hi;
      end

      S_WR2: begin
        w_next_state = S_IDLE;
      end

      S_RD_CMD: begin
        w_next_state = S_RD_WAIT;
        w_have_lo    = 1'b0;
      end

      S_RD_WAIT: begin
        if (w_second_beat) begin
          w_next_state   = S_IDLE;
          w_rd_out       = {rd_data_fifo_out, r_beat_lo};
          w_rd_out_valid = 1'b1;
          w_have_lo      = 1'b0;
        end else if (w_to_expire) begin
          // Abandon the read; any partial beat is dropped.
          w_next_state = S_IDLE;
          w_have_lo    = 1'b0;
        end else if (rd_data_valid) begin
          w_beat_lo = rd_data_fifo_out;
          w_have_lo = 1'b1;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk0_tb or posedge rst0_tb) begin
    if (rst0_tb) begin
      r_last_grant <= c_LG_RESET;
      r_data_hi    <= '0;
      r_beat_lo    <= '0;
      r_have_lo    <= 1'b0;
      cmd          <= 3'b000;
      address      <= '0;
      af_we        <= 1'b0;
      wdf_we       <= 1'b0;
      w_data       <= '0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_out       <= '0;
      rd_out_valid <= 1'b0;
    end else begin
      r_last_grant <= w_last_grant;
      r_data_hi    <= w_data_hi;
      r_beat_lo    <= w_beat_lo;
      r_have_lo    <= w_have_lo;
      cmd          <= w_cmd;
      address      <= w_address;
      af_we        <= w_af_we;
      wdf_we       <= w_wdf_we;
      w_data       <= w_w_data;
      wr_ack       <= w_wr_ack;
      rd_ack       <= w_rd_ack;
      rd_out       <= w_rd_out;
      rd_out_valid <= w_rd_out_valid;
    end
  end

  // Beats seen outside RD_WAIT are counted and otherwise ignored.
  always_ff @(posedge clk0_tb or posedge rst0_tb) begin
    if (rst0_tb) begin
      r_stray <= 3'd0;
    end else if (rd_data_valid && (r_state != S_RD_WAIT) && (r_stray != 3'd7)) begin
      r_stray <= r_stray + 3'd1;
    end
  end

  assign debug = {r_state, r_last_grant, rd_timeout, r_stray};

endmodule
`default_nettype wire

// File: tb/tb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_arbiter
//  Description : Directed self-checking bench for ddr_arbiter; expected read
//                words are queued when beats are driven and popped when
//                rd_out_valid is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ddr_arbiter;

  logic         clk0_tb = 1'b0;
  logic         rst0_tb = 1'b1;
  logic         phy_init_done = 1'b0;
  logic         app_af_afull = 1'b0;
  logic         app_wdf_afull = 1'b0;
  logic [2:0]   cmd;
  logic [30:0]  address;
  logic         af_we;
  logic         wdf_we;
  logic [127:0] w_data;
  logic         rd_data_valid = 1'b0;
  logic [127:0] rd_data_fifo_out = '0;
  logic         wr_req = 1'b0;
  logic [30:0]  wr_addr = '0;
  logic [255:0] wr_data = '0;
  logic         wr_ack;
  logic         rd_req = 1'b0;
  logic [30:0]  rd_addr = '0;
  logic         rd_ack;
  logic [255:0] rd_out;
  logic         rd_out_valid;
  logic         rd_timeout;
  logic [7:0]   debug;

  ddr_arbiter #(.TIMEOUT_CYCLES(20), .WR_FIRST(1)) dut (
    .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .phy_init_done(phy_init_done),
    .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
    .cmd(cmd), .address(address), .af_we(af_we), .wdf_we(wdf_we), .w_data(w_data),
    .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_out(rd_out),
    .rd_out_valid(rd_out_valid), .rd_timeout(rd_timeout), .debug(debug)
  );

  always #5 clk0_tb = ~clk0_tb;

  int n_pass  = 0;
  int n_total = 0;
  logic [255:0] rd_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk0_tb);
    #1;
  endtask

  // Cycles spent waiting in RD_WAIT: no command may be issued.
  task automatic wait_rd(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("no_grant_in_rd_wait", af_we, 1'b0);
    end
  endtask

  task automatic read_beats(input logic [127:0] d0, input logic [127:0] d1);
    logic [255:0] exp;
    rd_q.push_back({d1, d0});
    rd_data_valid = 1'b1;
    rd_data_fifo_out = d0;
    tick();
    rd_data_fifo_out = d1;
    tick();
    rd_data_valid = 1'b0;
    rd_data_fifo_out = '0;
    chk("rd_out_valid_pulse", rd_out_valid, 1'b1);
    exp = rd_q.pop_front();
    chk("rd_out_data", rd_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_cmd", cmd, 3'b000);
    chk("rst_address", address, 31'h0);
    chk("rst_strobes", {af_we, wdf_we, wr_ack, rd_ack, rd_out_valid, rd_timeout}, 6'b0);
    chk("rst_w_data", w_data, 128'h0);
    chk("rst_rd_out", rd_out, 256'h0);
    chk("rst_debug", debug, 8'h00);
    rst0_tb = 1'b0;

    // ---------------- phy not ready: no grants ----------------
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 31'h8; rd_addr = 31'h8;
    seen = 1'b0;
    repeat (5) begin tick(); if (af_we) seen = 1'b1; end
    chk("phy_low_no_af_we", seen, 1'b0);
    wr_req = 1'b0; rd_req = 1'b0;
    phy_init_done = 1'b1;
    tick();

    // ---------------- single write ----------------
    wr_req = 1'b1; wr_addr = 31'h13; wr_data = {128'hB, 128'hA};
    tick();
    chk("wr1_af_we", af_we, 1'b1);
    chk("wr1_cmd", cmd, 3'b000);
    chk("wr1_address", address, 31'h10);
    chk("wr1_wdf_we", wdf_we, 1'b1);
    chk("wr1_w_data", w_data, 128'hA);
    chk("wr1_wr_ack", wr_ack, 1'b1);
    chk("wr1_state", debug[7:5], 3'd1);
    wr_req = 1'b0; wr_addr = '1; wr_data = '1;
    tick();
    chk("wr2_strobes", {af_we, wdf_we, wr_ack}, 3'b010);
    chk("wr2_w_data", w_data, 128'hB);
    chk("wr2_state", debug[7:5], 3'd2);
    tick();
    chk("wr_idle_strobes", {af_we, wdf_we}, 2'b00);
    chk("wr_idle_hold", {w_data, address}, {128'hB, 31'h10});
    chk("wr_idle_debug", debug[7:4], 4'b0001);

    // ---------------- single read ----------------
    rd_req = 1'b1; rd_addr = 31'h40;
    tick();
    chk("rdcmd_af_we", af_we, 1'b1);
    chk("rdcmd_cmd", cmd, 3'b001);
    chk("rdcmd_address", address, 31'h40);
    chk("rdcmd_rd_ack", rd_ack, 1'b1);
    chk("rdcmd_state", debug[7:5], 3'd3);
    rd_req = 1'b0; rd_addr = '0;
    tick();
    chk("rdwait_state", debug[7:5], 3'd4);
    chk("rdwait_rd_ack", rd_ack, 1'b0);
    wait_rd(2);
    read_beats(128'h1, 128'h2);
    tick();
    chk("rd_valid_one_cycle", rd_out_valid, 1'b0);
    chk("rd_out_hold", rd_out, {128'h2, 128'h1});
    chk("rd_done_state", debug[7:5], 3'd0);

    // ---------------- stray beats saturate ----------------
    rd_data_valid = 1'b1; rd_data_fifo_out = 128'h9;
    repeat (9) tick();
    rd_data_valid = 1'b0; rd_data_fifo_out = '0;
    chk("stray_saturate", debug[2:0], 3'd7);
    chk("stray_rd_out_hold", rd_out, {128'h2, 128'h1});

    // ---------------- contention W,R,W,R after reset ----------------
    rst0_tb = 1'b1;
    tick();
    chk("rst2_debug", debug, 8'h00);
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 31'h100; wr_data = {128'hD, 128'hC}; rd_addr = 31'h200;
    rst0_tb = 1'b0;
    tick();
    chk("cont_g1_W", {af_we, cmd}, {1'b1, 3'b000});
    tick(); tick();
    chk("cont_idle_gap", af_we, 1'b0);
    tick();
    chk("cont_g2_R", {af_we, cmd, address}, {1'b1, 3'b001, 31'h200});
    wait_rd(4);
    read_beats(128'h3, 128'h4);
    tick();
    chk("cont_g3_W", {af_we, cmd}, {1'b1, 3'b000});
    tick(); tick(); tick();
    chk("cont_g4_R", {af_we, cmd}, {1'b1, 3'b001});
    wr_req = 1'b0; rd_req = 1'b0;
    wait_rd(2);
    read_beats(128'h5, 128'h6);
    tick();

    // ---------------- write FIFO almost full: reads only ----------------
    app_wdf_afull = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1; rd_addr = 31'h300;
    tick();
    chk("afull_only_read", {af_we, cmd}, {1'b1, 3'b001});
    rd_req = 1'b0;
    wait_rd(2);
    read_beats(128'h7, 128'h8);
    seen = 1'b0;
    repeat (4) begin tick(); if (af_we) seen = 1'b1; end
    chk("afull_write_blocked", seen, 1'b0);
    wr_req = 1'b0; app_wdf_afull = 1'b0;
    tick();

    // ---------------- phy drop mid-write completes ----------------
    wr_req = 1'b1; wr_addr = 31'h2FF; wr_data = {128'hF, 128'hE};
    tick();
    chk("phydrop_wr1", {af_we, address, w_data}, {1'b1, 31'h2FC, 128'hE});
    phy_init_done = 1'b0;
    tick();
    chk("phydrop_wr2", {wdf_we, w_data}, {1'b1, 128'hF});
    seen = 1'b0;
    repeat (4) begin tick(); if (af_we) seen = 1'b1; end
    chk("phydrop_no_grant", seen, 1'b0);
    wr_req = 1'b0; phy_init_done = 1'b1;
    tick();

    // ---------------- read with one beat only ----------------
    rd_req = 1'b1; rd_addr = 31'h80;
    tick();
    chk("to_rdcmd", {af_we, cmd}, {1'b1, 3'b001});
    rd_req = 1'b0;
    tick();
    rd_data_valid = 1'b1; rd_data_fifo_out = 128'h77;
    tick();
    rd_data_valid = 1'b0; rd_data_fifo_out = '0;
    seen = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
    repeat (18) begin tick(); if (rd_out_valid) seen = 1'b1; end
    chk("to_before_expire", {rd_timeout, debug[7:5]}, {1'b0, 3'd4});
    tick();
    if (rd_out_valid) seen = 1'b1;
    chk("to_flag_set", rd_timeout, 1'b1);
    chk("to_state_idle", debug[7:5], 3'd0);
    chk("to_debug_bit", debug[3], 1'b1);
    tick();
    chk("to_sticky", rd_timeout, 1'b1);
    chk("to_no_valid", seen, 1'b0);
    chk("to_rd_out_hold", rd_out, {128'h8, 128'h7});
`else
    repeat (30) begin tick(); if (rd_out_valid) seen = 1'b1; end
    chk("nto_still_wait", debug[7:5], 3'd4);
    chk("nto_flag_zero", rd_timeout, 1'b0);
    chk("nto_no_valid", seen, 1'b0);
`endif

    // ---------------- reset asserted during WR2 ----------------
    rst0_tb = 1'b1;
    tick();
    rst0_tb = 1'b0;
    wr_req = 1'b1; wr_addr = 31'h55; wr_data = {128'hB2, 128'hA2};
    tick();
    wr_req = 1'b0;
    tick();
    chk("rstwr2_pre", {wdf_we, debug[7:5]}, {1'b1, 3'd2});
    #2 rst0_tb = 1'b1;
    #1;
    chk("rstwr2_strobes", {af_we, wdf_we, wr_ack, rd_ack, rd_out_valid}, 5'b0);
    chk("rstwr2_data", {cmd, address, w_data}, {3'b0, 31'h0, 128'h0});
    chk("rstwr2_state", debug[7:5], 3'd0);
    @(negedge clk0_tb);
    rst0_tb = 1'b0;
    seen = 1'b0;
    repeat (4) begin tick(); if (wr_ack || wdf_we) seen = 1'b1; end
    chk("rstwr2_no_ack", seen, 1'b0);
    rd_data_valid = 1'b1; rd_data_fifo_out = 128'h5A;
    tick();
    rd_data_valid = 1'b0;
    chk("post_rst_stray", debug[2:0], 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
